// File: rtl/input_debounce.sv
// Push-button debouncer: two-flop synchronisers, tick-gated agreement FSM, clean level plus press/release pulses.
// Optional auto-repeat pulses on a held button when INPUT_DEBOUNCE_AUTOREPEAT_EN is defined.
module input_debounce #(
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int CNT_W            = 4,
  parameter bit BTN_ACTIVE_LOW   = 1'b0,
  parameter int REPEAT_DELAY     = 50,
  parameter int REPEAT_PERIOD    = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             btn_sync1, btn_sync2;
  logic             tick_sync1, tick_sync2, tick_prev, tick_pulse;
  logic             btn_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // tick_in is a divided clock used purely as data; its rising edge becomes a one-clk strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1  <= 1'b0;
      btn_sync2  <= 1'b0;
      tick_sync1 <= 1'b0;
      tick_sync2 <= 1'b0;
      tick_prev  <= 1'b0;
      tick_pulse <= 1'b0;
    end else begin
      btn_sync1  <= btn_raw;
      btn_sync2  <= btn_sync1;
      tick_sync1 <= tick_in;
      tick_sync2 <= tick_sync1;
      tick_prev  <= tick_sync2;
      tick_pulse <= tick_sync2 & ~tick_prev;
    end
  end

  assign btn_s   = btn_sync2 ^ BTN_ACTIVE_LOW;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (tick_pulse) begin
        case (state)
          IDLE: begin
            if (btn_s) begin
              state <= PRESS_CHK;
              cnt   <= CNT_W'(1);
            end
          end
          PRESS_CHK: begin
            if (!btn_s) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= HELD;
              cnt       <= '0;
              btn_level <= 1'b1;
              btn_press <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          HELD: begin
            if (!btn_s) begin
              state <= RELEASE_CHK;
              cnt   <= CNT_W'(1);
            end
          end
          RELEASE_CHK: begin
            if (btn_s) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state       <= IDLE;
              cnt         <= '0;
              btn_level   <= 1'b0;
              btn_release <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_TOP    = REP_W'(REPEAT_DELAY);
  // After the first repeat the counter restarts PERIOD ticks below the threshold (PERIOD <= DELAY assumed).
  localparam logic [REP_W-1:0] REP_RELOAD =
    REP_W'((REPEAT_PERIOD > REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;

  assign rep_next = rep_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt    <= '0;
      btn_repeat <= 1'b0;
    end else begin
      btn_repeat <= 1'b0;
      if (state != HELD && state != RELEASE_CHK) begin
        rep_cnt <= '0;
      end else if (tick_pulse) begin
        if (rep_next == REP_TOP) begin
          rep_cnt    <= REP_RELOAD;
          btn_repeat <= (state == HELD) && btn_s;
        end else begin
          rep_cnt <= rep_next;
        end
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: stimulus pushes expected pulse events (kind + tick number),
// a negedge monitor pops and compares whenever a pulse appears.
module tb_input_debounce;

  localparam int EV_PRESS   = 1;
  localparam int EV_RELEASE = 2;
  localparam int EV_REPEAT  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic tick_in;
  logic btn_raw;
  logic btn_level, btn_press, btn_release, btn_repeat;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int tick_count = 0;
  logic prev_pulse = 1'b0;
  logic [15:0] exp_ev;
  int ev_code;

  input_debounce #(
    .DEBOUNCE_SAMPLES(4),
    .CNT_W(4),
    .BTN_ACTIVE_LOW(1'b0),
    .REPEAT_DELAY(5),
    .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick_in(tick_in),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_repeat(btn_repeat)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clk100 period of the freqdiv100 model: high 50 clk, low 50 clk.
  task automatic do_tick();
    tick_in = 1'b1;
    tick_count++;
    cycles(50);
    tick_in = 1'b0;
    cycles(50);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic expect_ev(input int code, input int t);
    exp_q.push_back(16'((code << 12) | (t & 16'h0fff)));
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_release", btn_release, 0);
    check("rst_repeat", btn_repeat, 0);
    #10 rst_n = 1'b1;
    cycles(5);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (btn_press || btn_release || btn_repeat) begin
        check("single_pulse_kind", int'(btn_press) + int'(btn_release) + int'(btn_repeat), 1);
        check("pulse_width", prev_pulse, 0);
        ev_code = btn_press ? EV_PRESS : (btn_release ? EV_RELEASE : EV_REPEAT);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", ev_code, 0);
        end else begin
          exp_ev = exp_q.pop_front();
          check("event_kind", ev_code, int'(exp_ev[15:12]));
          check("event_tick", tick_count & 16'h0fff, int'(exp_ev[11:0]));
        end
        if (btn_press)   check("level_on_press", btn_level, 1);
        if (btn_release) check("level_on_release", btn_level, 0);
      end
      prev_pulse <= btn_press | btn_release | btn_repeat;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  initial begin
    int base;
    rst_n   = 1'b0;
    tick_in = 1'b0;
    btn_raw = 1'b0;
    cycles(5);
    check("reset_level", btn_level, 0);
    check("reset_press", btn_press, 0);
    check("reset_release", btn_release, 0);
    check("reset_repeat", btn_repeat, 0);
    rst_n = 1'b1;
    cycles(5);

    // clean press then release
    btn_raw = 1'b1;
    cycles(10);
    expect_ev(EV_PRESS, tick_count + 4);
    ticks(4);
    check("level_after_press", btn_level, 1);
    btn_raw = 1'b0;
    expect_ev(EV_RELEASE, tick_count + 4);
    ticks(4);
    check("level_after_release", btn_level, 0);

    // press bounce: high 2, low 1, high 4
    btn_raw = 1'b1;
    ticks(2);
    check("level_during_bounce", btn_level, 0);
    btn_raw = 1'b0;
    ticks(1);
    btn_raw = 1'b1;
    expect_ev(EV_PRESS, tick_count + 4);
    ticks(4);
    check("level_after_bounced_press", btn_level, 1);

    // release bounce: low 2, high 1, low 4
    btn_raw = 1'b0;
    ticks(2);
    check("level_during_rel_bounce", btn_level, 1);
    btn_raw = 1'b1;
    ticks(1);
    btn_raw = 1'b0;
    expect_ev(EV_RELEASE, tick_count + 4);
    ticks(4);
    check("level_after_bounced_release", btn_level, 0);

    // reset mid-debounce with cnt = 3; held button must need 4 fresh ticks
    btn_raw = 1'b1;
    ticks(3);
    async_reset_pulse();
    expect_ev(EV_PRESS, tick_count + 4);
    ticks(4);
    check("level_after_reset_press", btn_level, 1);

    // reset while HELD clears level at once; still-held button recommits
    async_reset_pulse();
    expect_ev(EV_PRESS, tick_count + 4);
    ticks(4);
    check("level_recommit", btn_level, 1);
    btn_raw = 1'b0;
    expect_ev(EV_RELEASE, tick_count + 4);
    ticks(4);

    // tick-starved: free toggling must change nothing
    for (int i = 0; i < 1000; i++) begin
      btn_raw = 1'($urandom_range(0, 1));
      cycles(1);
    end
    btn_raw = 1'b0;
    cycles(10);
    check("level_tick_starved", btn_level, 0);

    // long hold: auto-repeat at held ticks 5, 7, 9, 11 when enabled
    btn_raw = 1'b1;
    expect_ev(EV_PRESS, tick_count + 4);
    ticks(4);
    base = tick_count;
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
    expect_ev(EV_REPEAT, base + 5);
    expect_ev(EV_REPEAT, base + 7);
    expect_ev(EV_REPEAT, base + 9);
    expect_ev(EV_REPEAT, base + 11);
`endif
    ticks(12);
    check("level_long_hold", btn_level, 1);
    btn_raw = 1'b0;
    expect_ev(EV_RELEASE, tick_count + 4);
    ticks(4);
    ticks(3);
    check("level_final", btn_level, 0);

    cycles(20);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
